// File: rtl/mfcc_mel_filter_acc.sv
// mfcc_mel_filter_acc -- mel-band energy accumulator for the MFCC front end.
//
// Streams one frame of power-spectrum bins, addresses the band's coefficient
// ROM with the bin index, weights each bin by the coefficient and sums the
// frame. At frame end one mel energy word (sum >> COEF_WIDTH) is offered over
// a valid/ready handshake.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   spec_valid/ready/data/last  input bin stream
//   rom_addr, rom_rd_data    coefficient ROM (registered, 1-cycle latency)
//   mel_valid/ready/data     mel energy output
//   frame_err                pulse when spec_last and frame length disagree
//
// Build option: define MEL_ACC_SAT_EN to saturate mel_data instead of
// keeping the low OUT_WIDTH bits.
module mfcc_mel_filter_acc #(
  parameter int ADDR_WIDTH = 9,
  parameter int COEF_WIDTH = 8,
  parameter int SPEC_WIDTH = 32,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spec_valid,
  output logic                  spec_ready,
  input  logic [SPEC_WIDTH-1:0] spec_data,
  input  logic                  spec_last,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [COEF_WIDTH-1:0] rom_rd_data,
  output logic                  mel_valid,
  input  logic                  mel_ready,
  output logic [OUT_WIDTH-1:0]  mel_data,
  output logic                  frame_err
);

  localparam int PW = SPEC_WIDTH + COEF_WIDTH;
  localparam int AW = PW + ADDR_WIDTH;
  localparam int SW = AW - COEF_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] bin_cnt;
  logic [SPEC_WIDTH-1:0] spec_q;
  logic                  s1_vld;
  logic [AW-1:0]         acc;
  logic [PW-1:0]         prod;
  logic [SW-1:0]         acc_shr;
  logic [OUT_WIDTH-1:0]  mel_next;
  logic                  accept;
  logic                  last_bin;
  logic                  eof;

  assign spec_ready = !rst && (state == IDLE || state == RUN);
  assign accept     = spec_valid && spec_ready;
  assign last_bin   = &bin_cnt;
  assign eof        = accept && (spec_last || last_bin);
  assign frame_err  = accept && (spec_last ^ last_bin);
  // ROM registers the address on the accepting edge; its data lines up with
  // spec_q one cycle later.
  assign rom_addr   = bin_cnt;
  assign prod       = PW'(spec_q) * PW'(rom_rd_data);
  assign acc_shr    = acc[AW-1:COEF_WIDTH];

`ifdef MEL_ACC_SAT_EN
  assign mel_next = (acc_shr > SW'({OUT_WIDTH{1'b1}})) ? {OUT_WIDTH{1'b1}}
                                                        : OUT_WIDTH'(acc_shr);
`else
  assign mel_next = OUT_WIDTH'(acc_shr);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bin_cnt   <= '0;
      spec_q    <= '0;
      s1_vld    <= 1'b0;
      acc       <= '0;
      mel_valid <= 1'b0;
      mel_data  <= '0;
    end else begin
      // stage 1: capture the bin alongside the ROM read
      s1_vld <= accept;
      if (accept) begin
        spec_q  <= spec_data;
        bin_cnt <= eof ? '0 : bin_cnt + ADDR_WIDTH'(1);
      end
      // stage 2: weight and accumulate
      if (s1_vld) acc <= acc + AW'(prod);

      case (state)
        IDLE:  if (accept) state <= eof ? DRAIN : RUN;
        RUN:   if (eof) state <= DRAIN;
        // first DRAIN cycle folds in the last product; leave once it is in acc
        DRAIN: if (!s1_vld) begin
          state     <= HOLD;
          mel_data  <= mel_next;
          mel_valid <= 1'b1;
          acc       <= '0;
        end
        HOLD:  if (mel_ready) begin
          state     <= IDLE;
          mel_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfcc_mel_filter_acc.sv
module tb_mfcc_mel_filter_acc;

  logic        clk_tb = 1'b0;
  logic        tb_rst;
  logic        spec_valid, spec_ready, spec_last;
  logic [31:0] spec_data;
  logic [8:0]  rom_addr;
  logic [7:0]  rom_rd_data;
  logic        mel_valid, mel_ready, frame_err;
  logic [31:0] mel_data;

  int checks = 0;
  int failures = 0;
  int rom_mode = 0;
  logic [31:0] sb[$];

  mfcc_mel_filter_acc dut (
    .clk(clk_tb), .rst(tb_rst),
    .spec_valid(spec_valid), .spec_ready(spec_ready),
    .spec_data(spec_data), .spec_last(spec_last),
    .rom_addr(rom_addr), .rom_rd_data(rom_rd_data),
    .mel_valid(mel_valid), .mel_ready(mel_ready),
    .mel_data(mel_data), .frame_err(frame_err)
  );

  always #5 clk_tb = ~clk_tb;

  function automatic logic [7:0] rom_val(input logic [8:0] a);
    case (rom_mode)
      0:       return a[7:0];
      1:       return 8'd128;
      default: return 8'hFF;
    endcase
  endfunction

  // registered ROM, 1-cycle latency
  always @(posedge clk_tb) rom_rd_data <= rom_val(rom_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s timeout", tag);
  endtask

  // Drive n bins (spec_last on index last_at, -1 = never). Expected energy is
  // modelled from the bins actually accepted and pushed to the scoreboard.
  task automatic drive_frame(input int n, input logic [31:0] d, input int last_at,
                             input bit gap, input int err_exp, input bit push);
    int i = 0;
    int cyc = 0;
    int errs = 0;
    logic [63:0] sum = 0;
    logic [63:0] shr;
    while (i < n) begin
      spec_valid = !(gap && cyc[0]);
      spec_data  = d;
      spec_last  = (i == last_at);
      @(negedge clk_tb);
      if (spec_valid && spec_ready) begin
        chk("rom_addr", rom_addr, i[8:0]);
        sum += 64'(d) * 64'(rom_val(i[8:0]));
        i++;
      end
      if (frame_err) errs++;
      @(posedge clk_tb);
      #1;
      cyc++;
      if (cyc > 5000) begin timeout("drive"); break; end
    end
    spec_valid = 1'b0;
    spec_last  = 1'b0;
    chk("frame_err_pulses", errs, err_exp);
    shr = sum >> 8;
`ifdef MEL_ACC_SAT_EN
    if (shr > 64'hFFFFFFFF) shr = 64'hFFFFFFFF;
`endif
    if (push) sb.push_back(shr[31:0]);
  endtask

  // Called #1 after the end-of-frame accept edge.
  task automatic wait_mel(input int stall);
    int lat = 0;
    bit got = 0;
    logic [31:0] exp_d;
    while (!got && lat < 50) begin
      @(posedge clk_tb);
      #1;
      lat++;
      if (mel_valid) got = 1;
    end
    exp_d = sb.pop_front();
    if (!got) begin timeout("mel_valid"); return; end
    chk("mel_latency", lat, 2);
    chk("mel_data", mel_data, exp_d);
    chk("ready_in_hold", spec_ready, 0);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk_tb);
      #1;
      chk("stall_valid", mel_valid, 1);
      chk("stall_data", mel_data, exp_d);
      chk("stall_ready", spec_ready, 0);
    end
    mel_ready = 1'b1;
    @(posedge clk_tb);
    #1;
    chk("post_hs_valid", mel_valid, 0);
    chk("post_hs_ready", spec_ready, 1);
  endtask

  initial begin
    tb_rst = 1'b1; spec_valid = 1'b0; spec_last = 1'b0; spec_data = '0; mel_ready = 1'b1;
    @(posedge clk_tb);
    @(posedge clk_tb);
    #1;
    chk("rst_spec_ready", spec_ready, 0);
    chk("rst_mel_valid", mel_valid, 0);
    chk("rst_mel_data", mel_data, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_frame_err", frame_err, 0);
    tb_rst = 1'b0;
    #1;
    chk("post_rst_ready", spec_ready, 1);

    // full frame, coefficient = address[7:0]
    rom_mode = 0;
    drive_frame(512, 32'd256, 511, 0, 0, 1);
    wait_mel(0);

    // same frame, bursty input, downstream stalls 10 cycles
    mel_ready = 1'b0;
    drive_frame(512, 32'd256, 511, 1, 0, 1);
    wait_mel(10);

    // short frame: spec_last on bin 99
    rom_mode = 1;
    drive_frame(100, 32'd1000, 99, 0, 1, 1);
    wait_mel(0);

    // no spec_last: frame closes on the 512th bin (also checks addr restarts at 0)
    drive_frame(512, 32'd1000, -1, 0, 1, 1);
    wait_mel(0);

    // maximal values: saturate or wrap depending on build
    rom_mode = 2;
    drive_frame(512, 32'hFFFFFFFF, 511, 0, 0, 1);
    wait_mel(0);

    // abort mid-frame, then a clean frame must show no residue
    drive_frame(300, 32'd5000, -1, 0, 0, 0);
    tb_rst = 1'b1;
    #1;
    chk("midrst_ready", spec_ready, 0);
    @(posedge clk_tb);
    #1;
    chk("midrst_mel_valid", mel_valid, 0);
    chk("midrst_rom_addr", rom_addr, 0);
    tb_rst = 1'b0;
    drive_frame(512, 32'd1, 511, 0, 0, 1);
    wait_mel(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mfcc_mel_filter_acc.md
# mfcc_mel_filter_acc

Mel-filter energy accumulator for the MFCC front end. It consumes one frame of power-spectrum bins from the FFT magnitude stage. For each bin it drives the address of a mel filterbank coefficient ROM, weights the bin by the returned coefficient, and accumulates the frame sum. At frame end it presents one mel-band energy word to the log/DCT stage over a valid/ready handshake. One instance is used per mel band, each paired with its own melbank ROM (for example the band-15 ROM).

## Interface
Parameters:
- `ADDR_WIDTH`, default 9: ROM address width; frame length is `N_BINS = 2**ADDR_WIDTH`.
- `COEF_WIDTH`, default 8: ROM coefficient width, unsigned Q0.COEF_WIDTH.
- `SPEC_WIDTH`, default 32: unsigned power-bin width.
- `OUT_WIDTH`, default 32: mel energy output width.

Ports:
- `clk`  in  1  Single clock for the whole block.
- `rst`  in  1  Synchronous, active-high reset.
- `spec_valid`  in  1  Input bin valid.
- `spec_ready`  out  1  Block can accept a bin.
- `spec_data`  in  SPEC_WIDTH  Power value of the bin.
- `spec_last`  in  1  Marks the last bin of the frame.
- `rom_addr`  out  ADDR_WIDTH  Coefficient ROM address.
- `rom_rd_data`  in  COEF_WIDTH  ROM data; registered ROM, 1-cycle latency, OUT_REG off.
- `mel_valid`  out  1  Mel energy available.
- `mel_ready`  in  1  Downstream accepts the energy word.
- `mel_data`  out  OUT_WIDTH  Mel energy, `(sum >> COEF_WIDTH)` reduced to OUT_WIDTH.
- `frame_err`  out  1  One-cycle pulse when the frame length and `spec_last` disagree.

## Operation
- States: IDLE, RUN, DRAIN, HOLD.
  - IDLE → RUN on the first accepted bin.
  - RUN → DRAIN on the end-of-frame bin.
  - DRAIN → HOLD after the pipeline empties (1 cycle).
  - HOLD → IDLE on `mel_valid & mel_ready`.
- Bin accept: `spec_valid & spec_ready`. `spec_ready = 1` in IDLE and RUN, `0` in DRAIN and HOLD.
- `bin_cnt` (ADDR_WIDTH bits) starts at 0 and increments per accepted bin. `rom_addr = bin_cnt`, combinational, so the ROM samples the address on the accepting edge.
- Stage 1, on accept: register `spec_data` and a stage-valid bit.
- Stage 2, next cycle: `acc += spec_q * rom_rd_data`.
  - Product: SPEC_WIDTH+COEF_WIDTH bits.
  - `acc`: SPEC_WIDTH+COEF_WIDTH+ADDR_WIDTH bits, unsigned, never overflows.
- End of frame is the earlier of:
  - an accepted bin with `spec_last = 1`, or
  - an accepted bin with `bin_cnt = N_BINS-1`.
- `frame_err` pulses in the end-of-frame accept cycle when exactly one of those two conditions holds.
- `bin_cnt` clears to 0 at end of frame, so wrap-around never carries into the next frame.
- On entering HOLD: `mel_data` is registered from `acc >> COEF_WIDTH`, `mel_valid = 1`, and `acc` clears. `mel_data` stays stable while `mel_valid & !mel_ready`.
- Bins with a zero coefficient are still accepted and consume a cycle; they contribute 0.

## Timing
- Reset values:
  - `spec_ready = 0` during the `rst` cycle, `1` in the first cycle after it.
  - `rom_addr = 0`, `mel_valid = 0`, `mel_data = 0`, `frame_err = 0`.
  - `acc = 0`, `bin_cnt = 0`, state IDLE.
- Throughput: 1 bin/cycle while RUN.
- Latency: `mel_valid` rises 2 cycles after the end-of-frame accept edge.
- Frame gap: at least 3 cycles before the next frame's first bin (DRAIN + HOLD + handshake cycle). More cycles if `mel_ready` is held low.
- `rst` asserted mid-frame or in HOLD: everything returns to reset values on that edge and the partial sum is discarded. A pending `mel_valid` is dropped without handshake.
- `spec_valid` while `spec_ready = 0`: ignored; the upstream holds its data.

## Configuration
- `MEL_ACC_SAT_EN`:
  - Defined: if `acc >> COEF_WIDTH` exceeds `2**OUT_WIDTH-1`, `mel_data` saturates to all ones.
  - Undefined: `mel_data` takes the low OUT_WIDTH bits (wraps), and the saturation comparator is not built.

## Test plan
- 512 bins of `spec_data = 256`, ROM coefficient = address[7:0], `spec_last` on bin 511 → `mel_data = 65280`, `mel_valid` 2 cycles after the last accept, `frame_err = 0`.
- Same frame with `spec_valid` toggled every other cycle and `mel_ready` held low 10 cycles → same `mel_data`, stable through the stall, `spec_ready = 0` in HOLD.
- `spec_last` on bin 99 (all bins 1000, coefficient 128) → `mel_data = 50000`, `frame_err` pulses once, next frame starts at `rom_addr = 0`.
- 512 bins without `spec_last` → frame closes at bin 511, `frame_err` pulses.
- All bins `0xFFFFFFFF`, coefficient 255 → `mel_data = 0xFFFFFFFF` with `MEL_ACC_SAT_EN`; without it, the low 32 bits of `(512*255*0xFFFFFFFF) >> 8`.
- `rst` asserted at bin 300, then a full frame of 1s with coefficient 256-complement 0xFF → `mel_data = 510`, with no residue from the aborted frame.
